// File: rtl/quadrature_pkg.sv
// rtl/quadrature_pkg.sv - shared types and Gray-code step decoder for the quadrature decoder
package quadrature_pkg;

    typedef enum logic [1:0] {X1, X2, X4} decode_mode_t;
    typedef enum logic {S_SETTLE, S_RUN} qd_state_t;
    typedef enum logic [1:0] {STEP_NONE, STEP_FWD, STEP_REV, STEP_ILLEGAL} step_t;

    // Position of phase {a,b} along the forward cycle 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] phase_pos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'd0;
            2'b10:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] curr);
        logic [1:0] delta;
        delta = phase_pos(curr) - phase_pos(prev);
        case (delta)
            2'd0:    return STEP_NONE;
            2'd1:    return STEP_FWD;
            2'd3:    return STEP_REV;
            default: return STEP_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/quadrature_decoder_filter.sv
// rtl/quadrature_decoder_filter.sv - per-channel synchroniser and persistence glitch filter
module glitch_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_raw,
    input  logic i_load,
    output logic o_sync,
    output logic o_filt
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          count;

    assign o_sync = sync_q[SYNC_STAGES-1];

    // A new level is accepted only after FILTER_LEN consecutive disagreeing cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            count  <= '0;
            o_filt <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_raw};
            if (i_load) begin
                o_filt <= o_sync;
                count  <= '0;
            end else if (o_sync != o_filt) begin
                if (count == CW'(FILTER_LEN - 1)) begin
                    o_filt <= o_sync;
                    count  <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end else begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/quadrature_decoder.sv
// rtl/quadrature_decoder.sv - quadrature A/B decoder producing inc/dec/error strobes
module quadrature_decoder
    import quadrature_pkg::*;
#(
    parameter int           SYNC_STAGES = 2,
    parameter int           FILTER_LEN  = 4,
    parameter decode_mode_t MODE        = X4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_a,
    input  logic i_b,
    input  logic i_enable,
    input  logic i_err_clr,
    output logic o_inc,
    output logic o_dec,
    output logic o_error,
    output logic o_error_sticky
);

    localparam int SW = $clog2(SYNC_STAGES + 1);

    qd_state_t   state, state_next;
    logic [SW-1:0] settle_count;
    logic        load;
    logic        sync_a, sync_b, filt_a, filt_b;
    logic [1:0]  filt_ab, prev_ab;
    step_t       step;
    logic        a_changed, inc_next, dec_next, err_next;

    glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filter_a (
        .clock(clock), .reset(reset), .i_raw(i_a), .i_load(load), .o_sync(sync_a), .o_filt(filt_a)
    );

    glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filter_b (
        .clock(clock), .reset(reset), .i_raw(i_b), .i_load(load), .o_sync(sync_b), .o_filt(filt_b)
    );

    assign filt_ab = {filt_a, filt_b};

    always_ff @(posedge clock) begin
        if (reset) state <= S_SETTLE;
        else       state <= state_next;
    end

    // The synchroniser output is only meaningful once SYNC_STAGES post-reset edges have filled it.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        if (state == S_SETTLE && settle_count == SW'(SYNC_STAGES)) begin
            load       = 1'b1;
            state_next = S_RUN;
        end
    end

    always_comb begin
        step      = decode_step(prev_ab, filt_ab);
        a_changed = prev_ab[1] ^ filt_ab[1];
        inc_next  = 1'b0;
        dec_next  = 1'b0;
        err_next  = 1'b0;
        if (state == S_RUN && i_enable) begin
            case (step)
                STEP_FWD: begin
                    case (MODE)
                        X4:      inc_next = 1'b1;
                        X2:      inc_next = a_changed;
                        default: inc_next = (prev_ab == 2'b00) && (filt_ab == 2'b10);
                    endcase
                end
                STEP_REV: begin
                    case (MODE)
                        X4:      dec_next = 1'b1;
                        X2:      dec_next = a_changed;
                        default: dec_next = (prev_ab == 2'b10) && (filt_ab == 2'b00);
                    endcase
                end
                STEP_ILLEGAL: err_next = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            settle_count   <= '0;
            prev_ab        <= 2'b00;
            o_inc          <= 1'b0;
            o_dec          <= 1'b0;
            o_error        <= 1'b0;
            o_error_sticky <= 1'b0;
        end else begin
            if (state == S_SETTLE && !load) settle_count <= settle_count + 1'b1;
            prev_ab <= load ? {sync_a, sync_b} : filt_ab;
            o_inc   <= inc_next;
            o_dec   <= dec_next;
            o_error <= err_next;
            if (err_next)       o_error_sticky <= 1'b1;
            else if (i_err_clr) o_error_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_quadrature_decoder.sv
// tb/tb_quadrature_decoder.sv - self-checking bench for quadrature_decoder in X4, X2 and X1 modes
module tb_quadrature_decoder;
    import quadrature_pkg::*;

    logic clock = 1'b0;
    logic reset, a, b, enable, err_clr;
    logic inc4, dec4, err4, stk4;
    logic inc2, dec2, err2, stk2;
    logic inc1, dec1, err1, stk1;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    bit mon_on = 1'b0;

    localparam int LAT = 7;

    typedef struct packed {
        int   cyc;
        logic inc4, dec4, inc2, dec2, inc1, dec1, err;
    } exp_t;

    typedef struct packed {
        logic a, b, en;
        logic inc4, dec4, inc2, dec2, inc1, dec1, err;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs [0:13];

    quadrature_decoder #(.SYNC_STAGES(2), .FILTER_LEN(4), .MODE(X4)) dut_x4 (
        .clock(clock), .reset(reset), .i_a(a), .i_b(b), .i_enable(enable), .i_err_clr(err_clr),
        .o_inc(inc4), .o_dec(dec4), .o_error(err4), .o_error_sticky(stk4)
    );
    quadrature_decoder #(.SYNC_STAGES(2), .FILTER_LEN(4), .MODE(X2)) dut_x2 (
        .clock(clock), .reset(reset), .i_a(a), .i_b(b), .i_enable(enable), .i_err_clr(err_clr),
        .o_inc(inc2), .o_dec(dec2), .o_error(err2), .o_error_sticky(stk2)
    );
    quadrature_decoder #(.SYNC_STAGES(2), .FILTER_LEN(4), .MODE(X1)) dut_x1 (
        .clock(clock), .reset(reset), .i_a(a), .i_b(b), .i_enable(enable), .i_err_clr(err_clr),
        .o_inc(inc1), .o_dec(dec1), .o_error(err1), .o_error_sticky(stk1)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
        end
    endtask

    // Expected strobe bits {inc4,dec4,inc2,dec2,inc1,dec1,err}, due LAT cycles after the drive.
    task automatic expect_at(input logic [6:0] bits);
        sb.push_back({cyc + LAT, bits});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (mon_on) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                mon_e = sb.pop_front();
                chk("strobes", {inc4, dec4, inc2, dec2, inc1, dec1, err4, err2, err1},
                    {mon_e.inc4, mon_e.dec4, mon_e.inc2, mon_e.dec2, mon_e.inc1, mon_e.dec1,
                     mon_e.err, mon_e.err, mon_e.err});
            end else begin
                chk("idle", {inc4, dec4, inc2, dec2, inc1, dec1, err4, err2, err1}, 32'h0);
            end
        end
    end

    initial begin
        // a b en | inc4 dec4 inc2 dec2 inc1 dec1 | err
        vecs[0]  = 10'b101_10_10_10_0;
        vecs[1]  = 10'b111_10_00_00_0;
        vecs[2]  = 10'b011_10_10_00_0;
        vecs[3]  = 10'b001_10_00_00_0;
        vecs[4]  = 10'b011_01_00_00_0;
        vecs[5]  = 10'b111_01_01_00_0;
        vecs[6]  = 10'b101_01_00_00_0;
        vecs[7]  = 10'b001_01_01_01_0;
        vecs[8]  = 10'b010_00_00_00_0;
        vecs[9]  = 10'b110_00_00_00_0;
        vecs[10] = 10'b100_00_00_00_0;
        vecs[11] = 10'b000_00_00_00_0;
        vecs[12] = 10'b101_10_10_10_0;
        vecs[13] = 10'b001_01_01_01_0;

        a = 1'b1; b = 1'b1; enable = 1'b1; err_clr = 1'b0; reset = 1'b1;
        wait_cycles(3);
        mon_on = 1'b1;
        chk("reset_outputs", {inc4, dec4, err4, stk4, inc2, dec2, err2, stk2, inc1, dec1, err1, stk1}, 32'h0);
        reset = 1'b0;
        wait_cycles(20);

        a = 1'b0; expect_at(7'b10_10_00_0);
        wait_cycles(10);
        b = 1'b0; expect_at(7'b10_00_00_0);
        wait_cycles(10);

        for (int i = 0; i < 14; i++) begin
            a = vecs[i].a; b = vecs[i].b; enable = vecs[i].en;
            expect_at({vecs[i].inc4, vecs[i].dec4, vecs[i].inc2, vecs[i].dec2,
                       vecs[i].inc1, vecs[i].dec1, vecs[i].err});
            wait_cycles(10);
        end

        // Three-cycle pulse is rejected; four-cycle pulse passes as a step and its return.
        a = 1'b1; wait_cycles(3); a = 1'b0; wait_cycles(15);
        a = 1'b1; expect_at(7'b10_10_10_0);
        wait_cycles(4);
        a = 1'b0; expect_at(7'b01_01_01_0);
        wait_cycles(15);

        a = 1'b1; b = 1'b1; expect_at(7'b00_00_00_1);
        wait_cycles(LAT);
        chk("sticky_set", {stk4, stk2, stk1}, 32'h7);
        wait_cycles(3);
        err_clr = 1'b1; wait_cycles(1); err_clr = 1'b0;
        chk("sticky_clear", {stk4, stk2, stk1}, 32'h0);
        a = 1'b0; b = 1'b0; expect_at(7'b00_00_00_1);
        wait_cycles(LAT - 1);
        err_clr = 1'b1; wait_cycles(1); err_clr = 1'b0;
        chk("sticky_set_beats_clear", {stk4, stk2, stk1}, 32'h7);
        wait_cycles(10);

        // Reset two cycles into filtering an A edge; settle must adopt phase 10 silently.
        a = 1'b1;
        wait_cycles(4);
        reset = 1'b1;
        wait_cycles(1);
        chk("midreset_outputs", {inc4, dec4, err4, stk4, inc2, dec2, err2, stk2, inc1, dec1, err1, stk1}, 32'h0);
        wait_cycles(1);
        reset = 1'b0;
        wait_cycles(20);
        a = 1'b0; expect_at(7'b01_01_01_0);
        wait_cycles(12);
        chk("sticky_after_reset", {stk4, stk2, stk1}, 32'h0);

        chk("scoreboard_drained", sb.size(), 32'h0);
        mon_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/quadrature_decoder.md
Name: quadrature_decoder

Overview:
Upstream stage for the up/down position counter. Takes raw asynchronous quadrature encoder lines A/B and synchronises and glitch-filters them. Decodes the Gray-code phase sequence into single-cycle increment/decrement strobes that drive the counter's i_inc/i_dec directly. Also flags illegal (two-bit) phase jumps.

Parameters:
SYNC_STAGES, 2, synchroniser depth per channel (>=2).
FILTER_LEN, 4, consecutive cycles a synchronised level must differ from the filtered level before it is accepted (>=1).
MODE, X4, decode resolution from package enum: X1, X2, X4.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
i_a  input  1  raw encoder channel A (asynchronous)
i_b  input  1  raw encoder channel B (asynchronous)
i_enable  input  1  1 = emit strobes/errors; 0 = track phase silently
i_err_clr  input  1  clears o_error_sticky
o_inc  output  1  one-cycle forward step strobe
o_dec  output  1  one-cycle reverse step strobe
o_error  output  1  one-cycle illegal-transition strobe
o_error_sticky  output  1  latched error flag

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset values:
  - All outputs 0.
  - Synchroniser flops 0.
  - Filter counters 0.
  - FSM enters S_SETTLE.
- FSM states:
  - S_SETTLE: counts SYNC_STAGES cycles.
    - On the last settle cycle, load filtered {a,b} and prev {a,b} directly from the synchroniser outputs, then go to S_RUN.
    - No strobes are ever emitted in S_SETTLE.
  - S_RUN: normal operation. Only reset leaves S_RUN.
- Filter, per channel, independent:
  - Counter width $clog2(FILTER_LEN+1).
  - If sync != filt, the counter increments. When it would reach FILTER_LEN, filt <= sync and the counter clears.
  - If sync == filt, the counter clears, so any glitch shorter than FILTER_LEN cycles is rejected.
- Phase code is {a,b}.
  - Forward (A leads): 00 -> 10 -> 11 -> 01 -> 00.
  - Reverse is the opposite order.
- Decode each S_RUN cycle, comparing filtered {a,b} against prev:
  - Equal: nothing.
  - One-bit change in forward order: forward step.
  - One-bit change in reverse order: reverse step.
  - Both bits changed: illegal, no step.
  - prev <= filtered every cycle, regardless of i_enable or MODE.
- MODE gating of steps:
  - X4: every step produces a strobe.
  - X2: only steps in which A changed.
  - X1: only 00 -> 10 (inc) and 10 -> 00 (dec).
- Outputs are registered: strobe appears the cycle after the filtered change.
  - Total latency from a raw edge held stable = SYNC_STAGES + FILTER_LEN + 1 cycles (7 at defaults).
- o_inc and o_dec are never high together. At most one strobe per cycle, which matches the consumer's one-step-per-cycle semantics.
- i_enable = 0:
  - o_inc, o_dec and o_error are forced 0.
  - Phase tracking continues, so re-enabling does not emit a spurious step.
- o_error_sticky:
  - Set when o_error is set.
  - Cleared by i_err_clr.
  - Set wins over a simultaneous clear.
- Reset mid-operation: all filter progress is discarded, the FSM re-enters S_SETTLE, and no strobe is emitted for a partially filtered edge.

Decomposition:
- Package quadrature_pkg:
  - Enum decode_mode_t {X1, X2, X4}.
  - Enum qd_state_t {S_SETTLE, S_RUN}.
  - Enum step_t {STEP_NONE, STEP_FWD, STEP_REV, STEP_ILLEGAL}.
  - Function decode_step(prev, curr) returning step_t.
- Sub-module glitch_filter (params SYNC_STAGES, FILTER_LEN; ports clock, reset, i_raw, i_load, o_sync, o_filt), instantiated once per channel. i_load forces filt <= sync for settle.
- Top level holds the FSM, prev register, MODE gating and error logic.

Test Plan:
All scenarios use defaults (SYNC_STAGES = 2, FILTER_LEN = 4, MODE = X4) unless noted.
1. Hold a=1,b=1 through reset and settle -> no strobes. Step to {0,1} and hold 10 cycles -> o_inc high for exactly one cycle, 7 cycles after the change; o_dec never asserts.
2. Full forward cycle 00->10->11->01->00, each phase held 10 cycles -> 4 o_inc strobes. Repeat with MODE=X2 -> 2 strobes; MODE=X1 -> 1 strobe.
3. Full reverse cycle 00->01->11->10->00 -> 4 o_dec strobes and 0 o_inc. Run with i_enable=0 -> no strobes, then re-enable and make one forward step -> exactly 1 o_inc.
4. Pulse a high for 3 cycles from 00 -> no output. Pulse a high for 4 cycles -> o_inc then o_dec (one each), 4 cycles apart.
5. From 00, drive a and b to 1 on the same edge -> one o_error, o_error_sticky=1, no inc/dec. Assert i_err_clr in the same cycle as a new error -> sticky stays 1; assert it alone later -> sticky=0.
6. Assert reset 2 cycles into filtering an A edge -> all outputs 0, re-settle to the current {a,b}, and no strobe for that edge.
